// File: rtl/mc_rtype_core.sv
// mc_rtype_core: multi-cycle R-type core.
// Datapath: byte PC, synchronous instruction memory, register file and ALU.
// The FETCH/DECODE/EXEC/WB sequence is wrapped by IDLE and HALT states.
// The host loads a program through load_*, seeds or inspects registers through
// dbg_*, pulses start, and then watches wb_* and halted.
// Optional feature: define SLT_EN to add SLT (funct 0x2A) and SLTU (funct 0x2B).
module mc_rtype_core #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int IMEM_AW = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 load_we,
  input  logic [IMEM_AW-1:0]   load_addr,
  input  logic [31:0]          load_data,
  input  logic                 dbg_we,
  input  logic [REG_AW-1:0]    dbg_addr,
  input  logic [DATA_W-1:0]    dbg_wdata,
  output logic [DATA_W-1:0]    dbg_rdata,
  output logic                 busy,
  output logic                 halted,
  output logic [IMEM_AW+1:0]   pc,
  output logic                 wb_valid,
  output logic [REG_AW-1:0]    wb_addr,
  output logic [DATA_W-1:0]    wb_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam int IMEM_WORDS = 2 ** IMEM_AW;
  localparam int NUM_REGS   = 2 ** REG_AW;

  state_t            state;
  logic [31:0]       imem [0:IMEM_WORDS-1];
  logic [31:0]       ir;
  logic [DATA_W-1:0] rf [0:NUM_REGS-1];
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] res;

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic              wb_en;
  logic              unused_ir;

  // Field extraction; register indices take the low REG_AW bits of each field.
  assign op        = ir[31:26];
  assign funct     = ir[5:0];
  assign rs        = ir[21 +: REG_AW];
  assign rt        = ir[16 +: REG_AW];
  assign rd        = ir[11 +: REG_AW];
  assign unused_ir = ^{ir[25:21], ir[20:16], ir[15:11], ir[10:6]};

  assign busy   = (state == S_FETCH) || (state == S_DECODE) ||
                  (state == S_EXEC)  || (state == S_WB);
  assign halted = (state == S_HALT);

  // r0 reads as zero regardless of storage contents.
  assign dbg_rdata = (dbg_addr == '0) ? '0 : rf[dbg_addr];

  // Reports which funct codes the ALU implements.
  // Anything else still advances the PC, but it never writes a register.
  function automatic logic funct_ok(input logic [5:0] f);
    logic ok;
    ok = 1'b0;
    case (f)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27: ok = 1'b1;
`ifdef SLT_EN
      6'h2A, 6'h2B:                             ok = 1'b1;
`endif
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Wrap-around ALU with no flags.
  function automatic logic [DATA_W-1:0] alu(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic [5:0]        f);
    logic [DATA_W-1:0] r;
    r = '0;
    case (f)
      6'h20:   r = a + b;
      6'h22:   r = a - b;
      6'h24:   r = a & b;
      6'h25:   r = a | b;
      6'h26:   r = a ^ b;
      6'h27:   r = ~(a | b);
`ifdef SLT_EN
      6'h2A:   r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      6'h2B:   r = {{(DATA_W-1){1'b0}}, (a < b)};
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  assign wb_en = (state == S_WB) && (op == 6'h00) && funct_ok(funct) && (rd != '0);

  // Instruction memory: host loads happen only while idle.
  // FETCH performs a registered read into ir. This block has no reset, so the
  // memory can map onto block RAM.
  always_ff @(posedge clk) begin
    if (load_we && !busy)
      imem[load_addr] <= load_data;
    if (state == S_FETCH)
      ir <= imem[pc[IMEM_AW+1:2]];
  end

  // Register file: write-back from WB, or a debug write while idle. r0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        rf[i] <= '0;
    end else if (wb_en) begin
      rf[rd] <= res;
    end else if (dbg_we && !busy && (dbg_addr != '0)) begin
      rf[dbg_addr] <= dbg_wdata;
    end
  end

  // Execute FSM: PC, operand and result latches, and the registered write-back strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (op == 6'h3F) begin
            state <= S_HALT;
          end else begin
            op_a  <= rf[rs];
            op_b  <= rf[rt];
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          res   <= alu(op_a, op_b, funct);
          state <= S_WB;
        end
        S_WB: begin
          if (wb_en) begin
            wb_valid <= 1'b1;
            wb_addr  <= rd;
            wb_data  <= res;
          end
          pc    <= pc + (IMEM_AW + 2)'(4);
          state <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_rtype_core.sv
// tb_mc_rtype_core: directed bench for mc_rtype_core.
// Expected write-backs, including their arrival cycle, go into a scoreboard
// queue when start is driven. A negedge monitor pops an entry and compares it
// each time wb_valid fires. Honours SLT_EN in the same way as the design.
module tb_mc_rtype_core;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int IMEM_AW = 6;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                load_we = 1'b0;
  logic [IMEM_AW-1:0]  load_addr = '0;
  logic [31:0]         load_data = '0;
  logic                dbg_we = 1'b0;
  logic [REG_AW-1:0]   dbg_addr = '0;
  logic [DATA_W-1:0]   dbg_wdata = '0;
  logic [DATA_W-1:0]   dbg_rdata;
  logic                busy;
  logic                halted;
  logic [IMEM_AW+1:0]  pc;
  logic                wb_valid;
  logic [REG_AW-1:0]   wb_addr;
  logic [DATA_W-1:0]   wb_data;

  typedef struct {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    int                due;
  } wb_exp_t;

  wb_exp_t wb_q[$];
  int assert_count = 0;
  int fail_count   = 0;
  int cyc          = 0;
  int wb_seen      = 0;

  mc_rtype_core #(.DATA_W(DATA_W), .REG_AW(REG_AW), .IMEM_AW(IMEM_AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .busy(busy), .halted(halted), .pc(pc),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  // 10 ns clock, plus a cycle counter that the scoreboard uses for timing
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Hard stop so that a wedged design cannot hang the run
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [31:0] rtype(input int rs_i, input int rt_i, input int rd_i,
                                        input logic [5:0] fn);
    return {6'd0, 5'(rs_i), 5'(rt_i), 5'(rd_i), 5'd0, fn};
  endfunction

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Scoreboard monitor: every write-back must match the next expected entry
  always @(negedge clk) begin
    if (rst && wb_valid) begin
      wb_seen++;
      if (wb_q.size() == 0) begin
        check_output("wb_unexpected", {59'd0, wb_addr}, 64'hFFFF);
      end else begin
        wb_exp_t e;
        e = wb_q.pop_front();
        check_output("wb_addr", {59'd0, wb_addr}, {59'd0, e.addr});
        check_output("wb_data", {32'd0, wb_data}, {32'd0, e.data});
        check_output("wb_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Queues the k-th write-back of the program that is about to be started on this negedge
  task automatic expect_wb(input int addr, input logic [31:0] data, input int k);
    wb_exp_t e;
    e.addr = 5'(addr);
    e.data = data;
    e.due  = cyc + 5 + 4 * k;
    wb_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic do_start, input logic do_load,
                                input int la, input logic [31:0] ld,
                                input logic do_dbg, input int da, input logic [31:0] dd);
    start     = do_start;
    load_we   = do_load;
    load_addr = 6'(la);
    load_data = ld;
    dbg_we    = do_dbg;
    dbg_addr  = 5'(da);
    dbg_wdata = dd;
    @(negedge clk);
    start   = 1'b0;
    load_we = 1'b0;
    dbg_we  = 1'b0;
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    apply_stimulus(1'b0, 1'b1, a, d, 1'b0, 0, 32'd0);
  endtask

  task automatic dbg_write(input int a, input logic [31:0] d);
    apply_stimulus(1'b0, 1'b0, 0, 32'd0, 1'b1, a, d);
  endtask

  task automatic pulse_start();
    apply_stimulus(1'b1, 1'b0, 0, 32'd0, 1'b0, 0, 32'd0);
  endtask

  task automatic check_reg(input string tag, input int a, input logic [31:0] exp_v);
    dbg_addr = 5'(a);
    #1;
    check_output(tag, {32'd0, dbg_rdata}, {32'd0, exp_v});
  endtask

  task automatic wait_halt(input int budget, output int seen_cyc);
    seen_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (halted) begin
        seen_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    check_output("halt_reached", {63'd0, halted}, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int base;
    int hc;
    int wb_before;

    $display("[TB] reset and idle");
    @(negedge clk);
    do_reset();
    check_output("rst_busy", {63'd0, busy}, 64'd0);
    check_output("rst_halted", {63'd0, halted}, 64'd0);
    check_output("rst_pc", {56'd0, pc}, 64'd0);
    check_output("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    for (int r = 1; r < 32; r++)
      check_reg("rst_reg", r, 32'd0);

    $display("[TB] ADD/SUB then halt");
    dbg_write(1, 32'd5);
    dbg_write(2, 32'd3);
    load_word(0, 32'h0022_1820);
    load_word(1, 32'h0022_2022);
    load_word(2, HALT_W);
    base = cyc;
    expect_wb(3, 32'd8, 0);
    expect_wb(4, 32'd2, 1);
    pulse_start();
    wait_halt(40, hc);
    check_output("halt_cycle", 64'(hc), 64'(base + 11));
    check_output("halt_pc", {56'd0, pc}, 64'd8);
    check_output("halt_busy", {63'd0, busy}, 64'd0);
    check_reg("add_r3", 3, 32'd8);
    check_reg("sub_r4", 4, 32'd2);
    check_output("wb_pending_addsub", 64'(wb_q.size()), 64'd0);

    $display("[TB] r0 protection, unsupported funct, nonzero-op NOP");
    dbg_write(0, 32'h0000_FFFF);
    check_reg("dbg_r0", 0, 32'd0);
    load_word(0, 32'h0022_0020);
    load_word(1, rtype(1, 2, 5, 6'h21));
    load_word(2, 32'h0422_1820);
    load_word(3, HALT_W);
    wb_before = wb_seen;
    pulse_start();
    wait_halt(60, hc);
    check_output("nop_pc", {56'd0, pc}, 64'd12);
    check_output("nop_no_wb", 64'(wb_seen - wb_before), 64'd0);
    check_reg("nop_r0", 0, 32'd0);
    check_reg("nop_r5", 5, 32'd0);
    check_reg("nop_r3", 3, 32'd8);

    $display("[TB] ADD wrap-around");
    dbg_write(1, 32'hFFFF_FFFF);
    dbg_write(2, 32'd1);
    load_word(0, 32'h0022_1820);
    load_word(1, HALT_W);
    expect_wb(3, 32'd0, 0);
    pulse_start();
    wait_halt(40, hc);
    check_output("wrap_pc", {56'd0, pc}, 64'd4);
    check_reg("wrap_r3", 3, 32'd0);

    $display("[TB] SLT/SLTU");
    dbg_write(1, 32'hFFFF_FFFE);
    dbg_write(2, 32'd1);
    dbg_write(3, 32'h55);
    dbg_write(4, 32'h55);
    load_word(0, 32'h0022_182A);
    load_word(1, 32'h0022_202B);
    load_word(2, HALT_W);
`ifdef SLT_EN
    expect_wb(3, 32'd1, 0);
    expect_wb(4, 32'd0, 1);
`endif
    pulse_start();
    wait_halt(60, hc);
    check_output("slt_pc", {56'd0, pc}, 64'd8);
`ifdef SLT_EN
    check_reg("slt_r3", 3, 32'd1);
    check_reg("sltu_r4", 4, 32'd0);
`else
    check_reg("slt_r3", 3, 32'h55);
    check_reg("sltu_r4", 4, 32'h55);
`endif
    check_output("wb_pending_slt", 64'(wb_q.size()), 64'd0);

    $display("[TB] load/debug writes blocked while busy");
    dbg_write(1, 32'd5);
    dbg_write(2, 32'd3);
    load_word(0, 32'h0022_1820);
    load_word(1, HALT_W);
    expect_wb(3, 32'd8, 0);
    pulse_start();
    repeat (2) @(negedge clk);
    check_output("exec_busy", {63'd0, busy}, 64'd1);
    apply_stimulus(1'b1, 1'b1, 1, 32'h0022_1820, 1'b1, 7, 32'h1234);
    wait_halt(40, hc);
    check_output("blocked_pc", {56'd0, pc}, 64'd4);
    check_reg("blocked_r7", 7, 32'd0);

    $display("[TB] restart from HALT");
    dbg_write(3, 32'd0);
    expect_wb(3, 32'd8, 0);
    pulse_start();
    wait_halt(40, hc);
    check_output("restart_pc", {56'd0, pc}, 64'd4);
    check_reg("restart_r3", 3, 32'd8);
    check_output("wb_pending_restart", 64'(wb_q.size()), 64'd0);

    $display("[TB] reset mid-instruction");
    pulse_start();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("midrst_busy", {63'd0, busy}, 64'd0);
    check_output("midrst_pc", {56'd0, pc}, 64'd0);
    check_output("midrst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check_reg("midrst_r1", 1, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reg("midrst_r3", 3, 32'd0);

    $display("[TB] start and load on the same edge in IDLE");
    load_word(0, HALT_W);
    load_word(1, HALT_W);
    dbg_write(1, 32'd7);
    dbg_write(2, 32'd9);
    expect_wb(3, 32'd16, 0);
    apply_stimulus(1'b1, 1'b1, 0, 32'h0022_1820, 1'b0, 0, 32'd0);
    wait_halt(40, hc);
    check_output("simul_pc", {56'd0, pc}, 64'd4);
    check_reg("simul_r3", 3, 32'd16);

    $display("[TB] PC wrap with no halt");
    for (int w = 0; w < 64; w++)
      load_word(w, 32'h0022_0020);
    wb_before = wb_seen;
    pulse_start();
    repeat (252) @(negedge clk);
    check_output("pcwrap_252", {56'd0, pc}, 64'd252);
    repeat (4) @(negedge clk);
    check_output("pcwrap_0", {56'd0, pc}, 64'd0);
    check_output("pcwrap_busy", {63'd0, busy}, 64'd1);
    check_output("pcwrap_no_wb", 64'(wb_seen - wb_before), 64'd0);
    do_reset();
    check_output("wb_pending_end", 64'(wb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/mc_rtype_core.md
Name: mc_rtype_core

Overview:
- Parametrised multi-cycle successor to the single-cycle R-type datapath: PC, synchronous instruction memory, register file and ALU driven by a 4-state execute FSM.
- Adds a program-load port, a debug register port, start/halt control and a write-back strobe.
- Sits as the compute core under the board top; the host loads a program, pulses start and watches wb_*/halted.

Parameters:
DATA_W, 32, datapath and register width (>=8)
REG_AW, 5, register address width; 2**REG_AW registers, r0 hardwired 0
IMEM_AW, 6, instruction memory address width (word-addressed, 2**IMEM_AW words of 32 bits)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin execution from PC 0 (honoured in IDLE/HALT only)
load_we  in  1  write instruction word (honoured when busy=0)
load_addr  in  IMEM_AW  instruction word index
load_data  in  32  instruction word
dbg_we  in  1  write register (honoured when busy=0; ignored for r0)
dbg_addr  in  REG_AW  debug register index
dbg_wdata  in  DATA_W  debug write data
dbg_rdata  out  DATA_W  combinational read of rf[dbg_addr]
busy  out  1  high in FETCH/DECODE/EXEC/WB
halted  out  1  high in HALT
pc  out  IMEM_AW+2  byte PC, low 2 bits always 0
wb_valid  out  1  one-cycle pulse on register write-back
wb_addr  out  REG_AW  rd written
wb_data  out  DATA_W  value written

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=0, all registers 0, wb_valid=0, wb_addr=0, wb_data=0, busy=0, halted=0. Instruction memory contents are not reset.
- Instruction fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0]. Register indices use the low REG_AW bits of each 5-bit field.
- FSM:
  - IDLE: start -> FETCH, pc=0.
  - FETCH: ir <= imem[pc>>2] (synchronous read) -> DECODE.
  - DECODE: if op==6'h3F -> HALT (pc holds), else a <= rf[rs], b <= rf[rt] -> EXEC. Other nonzero op values are NOPs.
  - EXEC: res <= ALU(a,b,funct) -> WB.
  - WB: write rf[rd] if funct is supported, op==0 and rd!=0. pc <= pc+4, wrapping mod 2**(IMEM_AW+2). -> FETCH.
  - HALT: start -> FETCH, pc=0, registers retained.
- Each instruction takes exactly 4 cycles (FETCH..WB). HALT is reached 2 cycles after its FETCH.
- ALU, DATA_W-bit, wrap-around, no flags:
  - 0x20 ADD: a+b
  - 0x22 SUB: a-b
  - 0x24 AND
  - 0x25 OR
  - 0x26 XOR
  - 0x27 NOR
  - All other functs: unsupported, meaning no write and no wb_valid, but pc still advances.
- wb_valid is asserted for the cycle after WB (registered) with wb_addr/wb_data. It is not asserted for rd==0 or for unsupported instructions.
- start while busy: ignored.
- load_we/dbg_we while busy: ignored, with no side effect.
- Simultaneous start and load_we in IDLE: the load completes, then FETCH reads the new word (the write happens on the same edge as the FETCH transition, so FETCH sees it next cycle).
- dbg_we to r0: ignored. dbg_rdata for r0 is always 0.
- Reset asserted mid-instruction: immediate return to IDLE with reset values; a pending write-back is discarded.

Optional Feature:
- Macro SLT_EN.
- Defined: funct 0x2A SLT writes 1 if $signed(a) < $signed(b), else 0 (zero-extended to DATA_W). funct 0x2B SLTU does the same with an unsigned compare.
- Undefined: 0x2A and 0x2B are unsupported (no write, no wb_valid, pc advances).

Test Plan:
- Reset then idle: rst low for 2 cycles, then high -> busy=0, halted=0, pc=0, dbg_rdata=0 for r1..r31.
- ADD/SUB: dbg r1=5, r2=3; imem[0]=ADD r3,r1,r2 (0x00221820); imem[1]=SUB r4,r1,r2 (0x00222022); imem[2]=0xFC000000; start.
  - Expect wb_valid(r3=8) 4 cycles after start.
  - Expect wb_valid(r4=2) 4 cycles after that.
  - Expect halted=1 with pc=8.
- r0 protection: ADD r0,r1,r2, plus dbg_we to r0 with 0xFFFF -> no wb_valid, r0 stays 0.
- Wrap-around: r1=0xFFFFFFFF, r2=1, ADD -> 0x00000000. Fill the memory with ADD r0 NOPs and no halt -> pc wraps 252->0.
- Busy blocking: load_we and dbg_we pulsed during EXEC -> memory and registers unchanged. Restart from HALT re-executes from pc=0.
- SLT_EN: r1=0xFFFFFFFE (-2), r2=1, SLT r3 -> 1 and SLTU r4 -> 0. Without the macro, neither produces wb_valid.
